mubi4_rx_filter: RTL

//  Receive-side end of the MuBi4 signalling path: samples NumLanes mubi4_t control

---
 rtl/prim_mubi_pkg.sv | 24 ++
 rtl/mubi4_rx_lane_filter.sv | 81 ++++++++
 rtl/mubi4_rx_filter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/prim_mubi_pkg.sv
// prim_mubi_pkg: multi-bit boolean (MuBi4) encoding shared by encoders and the
// receive filter, plus the alert FSM state type and default filter depth used
// by mubi4_rx_filter.
package prim_mubi_pkg;

  typedef enum logic [3:0] {
    MuBi4True  = 4'h6,
    MuBi4False = 4'h9
  } mubi4_t;

  typedef enum logic [1:0] {
    MuBiRxIdle,
    MuBiRxAlert,
    MuBiRxWaitClr
  } mubi_rx_state_e;

  parameter int MuBiRxFilterDefault = 3;

  // Any pattern other than the two legal codes is a corrupted lane.
  function automatic logic mubi4_test_invalid(mubi4_t val);
    return !((val == MuBi4True) || (val == MuBi4False));
  endfunction

endpackage

// File: rtl/mubi4_rx_lane_filter.sv
// mubi4_rx_lane_filter: one MuBi4 lane. Registers the raw code, debounces it
// over FilterCycles identical valid samples and decodes it to a bool. An
// invalid code forces the lane to loose-false and raises a one-cycle fault.
// Ports:
//   clk_i, rst_ni  clock, async active-low reset
//   en_i           1 = decode/check active, 0 = lane frozen, counter held at 0
//   mubi_i[3:0]    raw lane code
//   bool_o         filtered value (1 = MuBi4True)
//   valid_o        lane holds a qualified value
//   fault_o        registered lane fault event
module mubi4_rx_lane_filter
  import prim_mubi_pkg::*;
#(
  parameter int FilterCycles = MuBiRxFilterDefault
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [3:0] mubi_i,
  output logic       bool_o,
  output logic       valid_o,
  output logic       fault_o
);

  localparam int CntW = $clog2(FilterCycles + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(FilterCycles);

  logic [3:0]      mubi_p0;
  logic [3:0]      mubi_p1;
  logic [CntW-1:0] cnt_p1;
  logic [CntW-1:0] cnt_d;
  logic            invalid;
  logic            same;

  // Stage p0: raw sample; p1: previous sample for the stability compare.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mubi_p0 <= MuBi4False;
      mubi_p1 <= MuBi4False;
    end else begin
      mubi_p0 <= mubi_i;
      mubi_p1 <= mubi_p0;
    end
  end

  always_comb begin
    invalid = mubi4_test_invalid(mubi4_t'(mubi_p0));
    same    = (mubi_p0 == mubi_p1);
    cnt_d   = cnt_p1;
    if (!en_i || invalid) begin
      cnt_d = '0;
    end else if (!same) begin
      cnt_d = CntW'(1);
    end else if (cnt_p1 != CntMax) begin
      cnt_d = cnt_p1 + CntW'(1);
    end
  end

  // Decode stage: counter, bool/valid and fault event.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_p1  <= '0;
      bool_o  <= 1'b0;
      valid_o <= 1'b0;
      fault_o <= 1'b0;
    end else begin
      cnt_p1  <= cnt_d;
      fault_o <= en_i & invalid;
      if (en_i) begin
        if (invalid) begin
          bool_o  <= 1'b0;
          valid_o <= 1'b0;
        end else if (cnt_d == CntMax) begin
          bool_o  <= (mubi_p0 == MuBi4True);
          valid_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mubi4_rx_filter.sv
// mubi4_rx_filter: receive-side MuBi4 decoder for NumLanes lanes. Each lane is
// debounced and decoded by mubi4_rx_lane_filter; any lane fault sets a sticky
// fault flag and drives a level alert to the safety controller until acked,
// after which clear_i returns the block to idle.
// Optional feature macro: MUBI_RX_FAULT_CNT_EN adds fault_cnt_o, a saturating
// count of fault-event cycles cleared only by reset.
// Ports:
//   clk_i, rst_ni   clock, async active-low reset
//   en_i            decode/check enable
//   mubi_i          lane k on mubi_i[4k+3:4k]
//   bool_o, valid_o per-lane decoded value / qualified flag
//   fault_o         sticky fault flag
//   fault_idx_o     lowest faulting lane captured at alert entry
//   alert_o         alert request, held until alert_ack_i
//   alert_ack_i     alert acknowledge
//   clear_i         clears fault_o once the alert was acked
//   fault_cnt_o     saturating fault-event count (macro only)
module mubi4_rx_filter
  import prim_mubi_pkg::*;
#(
`ifdef MUBI_RX_FAULT_CNT_EN
  parameter int FaultCntW    = 8,
`endif
  parameter int NumLanes     = 4,
  parameter int FilterCycles = MuBiRxFilterDefault,
  localparam int IdxW        = (NumLanes > 1) ? $clog2(NumLanes) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic [NumLanes*4-1:0] mubi_i,
  output logic [NumLanes-1:0]   bool_o,
  output logic [NumLanes-1:0]   valid_o,
  output logic                  fault_o,
  output logic [IdxW-1:0]       fault_idx_o,
  output logic                  alert_o,
  input  logic                  alert_ack_i,
`ifdef MUBI_RX_FAULT_CNT_EN
  output logic [FaultCntW-1:0]  fault_cnt_o,
`endif
  input  logic                  clear_i
);

  logic [NumLanes-1:0] lane_fault;
  logic                fault_ev;
  logic [IdxW-1:0]     lowest_idx;
  mubi_rx_state_e      state;

  for (genvar k = 0; k < NumLanes; k++) begin : g_lane
    mubi4_rx_lane_filter #(
      .FilterCycles(FilterCycles)
    ) u_lane (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en_i   (en_i),
      .mubi_i (mubi_i[4*k +: 4]),
      .bool_o (bool_o[k]),
      .valid_o(valid_o[k]),
      .fault_o(lane_fault[k])
    );
  end

  assign fault_ev = |lane_fault;

  // Descending scan so the lowest faulting lane wins.
  always_comb begin
    lowest_idx = '0;
    for (int k = NumLanes - 1; k >= 0; k--) begin
      if (lane_fault[k]) lowest_idx = IdxW'(k);
    end
  end

  // Alert stage: FSM with registered alert/fault outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= MuBiRxIdle;
      alert_o     <= 1'b0;
      fault_o     <= 1'b0;
      fault_idx_o <= '0;
    end else begin
      case (state)
        MuBiRxIdle: begin
          if (fault_ev) begin
            state       <= MuBiRxAlert;
            alert_o     <= 1'b1;
            fault_o     <= 1'b1;
            fault_idx_o <= lowest_idx;
          end
        end
        MuBiRxAlert: begin
          if (alert_ack_i) begin
            state   <= MuBiRxWaitClr;
            alert_o <= 1'b0;
          end
        end
        MuBiRxWaitClr: begin
          // A fault racing the clear keeps the block faulted and re-alerts.
          if (clear_i && fault_ev) begin
            state   <= MuBiRxAlert;
            alert_o <= 1'b1;
          end else if (clear_i) begin
            state   <= MuBiRxIdle;
            fault_o <= 1'b0;
          end
        end
        default: begin
          state   <= MuBiRxIdle;
          alert_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef MUBI_RX_FAULT_CNT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fault_cnt_o <= '0;
    end else if (fault_ev && (fault_cnt_o != '1)) begin
      fault_cnt_o <= fault_cnt_o + FaultCntW'(1);
    end
  end
`endif

endmodule
